// File: rtl/store_trace_display.sv
// store_trace_display
//   Snoops the core's data-memory store port into a small FIFO. Each captured
//   store is shown on four active-low 7-segment digits for HOLD_CYCLES clocks.
//   After that the next entry is shown, so short store bursts stay readable.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   mem_write  in   store strobe, one cycle per store
//   data_adr   in   store address, bits [7:0] captured
//   write_data in   store data, bits [7:0] captured
//   hex00      out  shown data[3:0]
//   hex01      out  shown data[7:4]
//   hex10      out  shown adr[3:0]
//   hex11      out  shown adr[7:4]
//   fifo_full  out  count == DEPTH
//   fifo_empty out  count == 0
//   overflow   out  sticky, a store was dropped
//
// state | meaning
// IDLE  | nothing on display (dashes), waiting for a queued store
// SHOW  | shown_q on display, hold_q counts down to the next advance
module store_trace_display #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] data_adr,
  input  logic [31:0] write_data,
  output logic [6:0]  hex00,
  output logic [6:0]  hex01,
  output logic [6:0]  hex10,
  output logic [6:0]  hex11,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
  localparam logic [6:0]    DASH        = 7'b0111111;

  typedef enum logic {IDLE, SHOW} state_e;

  state_e        state_q;
  logic [15:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [HW-1:0] hold_q;
  logic [15:0]   shown_q;
  logic          overflow_q;

  logic full;
  logic push_en;
  logic pop_en;
  logic unused_bits;

  assign unused_bits = ^{data_adr[31:8], write_data[31:8]};

  assign full = (count_q == FULL_COUNT);

  // The FSM pops from IDLE as soon as anything is queued, and from SHOW only
  // once the hold has expired. Both cases require a non-empty FIFO.
  assign pop_en  = (count_q != '0) && ((state_q == IDLE) || (hold_q == '0));
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push_en = mem_write && (!full || pop_en);

  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo_mem[wr_ptr_q] <= {data_adr[7:0], write_data[7:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_q     <= '0;
      shown_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (mem_write && full && !pop_en) begin
        overflow_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (pop_en) begin
            shown_q <= fifo_mem[rd_ptr_q];
            hold_q  <= HOLD_RELOAD;
            state_q <= SHOW;
          end
        end
        SHOW: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - HW'(1);
          end else if (pop_en) begin
            shown_q <= fifo_mem[rd_ptr_q];
            hold_q  <= HOLD_RELOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b0111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign hex00 = (state_q == SHOW) ? seg7(shown_q[3:0])   : DASH;
  assign hex01 = (state_q == SHOW) ? seg7(shown_q[7:4])   : DASH;
  assign hex10 = (state_q == SHOW) ? seg7(shown_q[11:8])  : DASH;
  assign hex11 = (state_q == SHOW) ? seg7(shown_q[15:12]) : DASH;

  assign fifo_full  = full;
  assign fifo_empty = (count_q == '0);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_store_trace_display.sv
module tb_store_trace_display;

  localparam int HOLD_A = 4;
  localparam int HOLD_B = 1;
  localparam logic [27:0] DASH4 = {4{7'b0111111}};
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b0111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mw_a = 1'b0, mw_b = 1'b0;
  logic [31:0] adr_a = '0, data_a = '0, adr_b = '0, data_b = '0;
  logic [6:0]  h00_a, h01_a, h10_a, h11_a, h00_b, h01_b, h10_b, h11_b;
  logic        full_a, empty_a, ovf_a, full_b, empty_b, ovf_b;
  logic [27:0] disp_a, disp_b;

  int n_checks = 0;
  int n_fail   = 0;
  int run_a = 0, run_b = 0;
  int flush_req_a = 0, flush_seen_a = 0;
  logic [27:0] q_a[$];
  logic [27:0] q_b[$];

  always #5 clk = ~clk;

  store_trace_display #(.DEPTH(4), .HOLD_CYCLES(HOLD_A)) dut_a (
    .clk(clk), .reset(reset), .mem_write(mw_a), .data_adr(adr_a), .write_data(data_a),
    .hex00(h00_a), .hex01(h01_a), .hex10(h10_a), .hex11(h11_a),
    .fifo_full(full_a), .fifo_empty(empty_a), .overflow(ovf_a));

  store_trace_display #(.DEPTH(4), .HOLD_CYCLES(HOLD_B)) dut_b (
    .clk(clk), .reset(reset), .mem_write(mw_b), .data_adr(adr_b), .write_data(data_b),
    .hex00(h00_b), .hex01(h01_b), .hex10(h10_b), .hex11(h11_b),
    .fifo_full(full_b), .fifo_empty(empty_b), .overflow(ovf_b));

  assign disp_a = {h11_a, h10_a, h01_a, h00_a};
  assign disp_b = {h11_b, h10_b, h01_b, h00_b};

  function automatic logic [27:0] pat(input logic [7:0] a, input logic [7:0] d);
    return {SEG[a[7:4]], SEG[a[3:0]], SEG[d[7:4]], SEG[d[3:0]]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every non-dash cycle must match the queue head, and
  // each entry must stay up for exactly its hold time before the next.
  always @(negedge clk) begin : mon_a
    if (flush_req_a != flush_seen_a) begin
      q_a.delete();
      run_a = 0;
      flush_seen_a = flush_req_a;
    end
    if (disp_a == DASH4) begin
      if (run_a != 0) check("hold_len_a", run_a, HOLD_A);
      run_a = 0;
    end else if (q_a.size() == 0) begin
      check("unexpected_a", {4'h0, disp_a}, {4'h0, DASH4});
    end else begin
      check("disp_a", {4'h0, disp_a}, {4'h0, q_a[0]});
      run_a++;
      if (run_a == HOLD_A) begin
        void'(q_a.pop_front());
        run_a = 0;
      end
    end
  end

  always @(negedge clk) begin : mon_b
    if (disp_b == DASH4) begin
      if (run_b != 0) check("hold_len_b", run_b, HOLD_B);
      run_b = 0;
    end else if (q_b.size() == 0) begin
      check("unexpected_b", {4'h0, disp_b}, {4'h0, DASH4});
    end else begin
      check("disp_b", {4'h0, disp_b}, {4'h0, q_b[0]});
      run_b++;
      if (run_b == HOLD_B) begin
        void'(q_b.pop_front());
        run_b = 0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the capturing edge.
  task automatic store_a(input logic [7:0] a, input logic [7:0] d, input bit shown);
    mw_a = 1'b1;
    adr_a = {24'h0, a};
    data_a = {24'hFFFFFF, d};
    if (shown) q_a.push_back(pat(a, d));
    @(negedge clk);
  endtask

  task automatic store_b(input logic [7:0] a, input logic [7:0] d);
    mw_b = 1'b1;
    adr_b = {24'hABCDEF, a};
    data_b = {24'h0, d};
    q_b.push_back(pat(a, d));
    @(negedge clk);
  endtask

  task automatic drain_a(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (q_a.size() == 0 && disp_a == DASH4) done = 1'b1;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    check("rst_hex_a", {4'h0, disp_a}, {4'h0, DASH4});
    check("rst_hex_b", {4'h0, disp_b}, {4'h0, DASH4});
    check("rst_empty", {31'd0, empty_a}, 32'd1);
    check("rst_full", {31'd0, full_a}, 32'd0);
    check("rst_ovf", {31'd0, ovf_a}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single store: queued after E0, on display after E1.
    store_a(8'h64, 8'h1A, 1'b1);
    mw_a = 1'b0;
    check("t1_not_empty", {31'd0, empty_a}, 32'd0);
    @(negedge clk);
    check("t1_latency", {4'h0, disp_a}, {4'h0, pat(8'h64, 8'h1A)});
    drain_a("t1_drain");
    check("t1_empty", {31'd0, empty_a}, 32'd1);

    // Burst of three.
    store_a(8'h20, 8'h01, 1'b1);
    store_a(8'h21, 8'h02, 1'b1);
    store_a(8'h22, 8'h03, 1'b1);
    mw_a = 1'b0;
    drain_a("t2_drain");
    check("t2_ovf", {31'd0, ovf_a}, 32'd0);

    // Back-to-back 0x10..0x16 from IDLE. 0x10 pops at E1 with a 4-cycle hold,
    // so the FIFO is full after E4, the E5 store meets the hold-expiry pop
    // (push+pop while full: accepted), and the E6 store is the one dropped.
    for (int k = 0; k < 7; k++) begin
      store_a(8'h80 + 8'(k), 8'h10 + 8'(k), k != 6);
      if (k == 4) begin
        check("t3_full", {31'd0, full_a}, 32'd1);
        check("t3_ovf_before", {31'd0, ovf_a}, 32'd0);
      end
      if (k == 5) begin
        check("t4_full_pushpop", {31'd0, full_a}, 32'd1);
        check("t4_ovf_unchanged", {31'd0, ovf_a}, 32'd0);
      end
      if (k == 6) check("t3_ovf_set", {31'd0, ovf_a}, 32'd1);
    end
    mw_a = 1'b0;
    drain_a("t3_drain");
    check("t3_ovf_sticky", {31'd0, ovf_a}, 32'd1);
    check("t3_empty", {31'd0, empty_a}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t3_ovf_cleared", {31'd0, ovf_a}, 32'd0);

    // Reset in cycle 2 of a hold with two entries still queued.
    store_a(8'h50, 8'h41, 1'b1);
    store_a(8'h51, 8'h42, 1'b1);
    store_a(8'h52, 8'h43, 1'b1);
    mw_a = 1'b0;
    check("t5_two_queued", {31'd0, empty_a}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 flush_req_a++;
    @(negedge clk);
    check("t5_dash", {4'h0, disp_a}, {4'h0, DASH4});
    check("t5_empty", {31'd0, empty_a}, 32'd1);
    check("t5_ovf", {31'd0, ovf_a}, 32'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("t5_never_shown", {4'h0, disp_a}, {4'h0, DASH4});

    // HOLD_CYCLES=1: consecutive single-cycle display.
    store_b(8'h3C, 8'hA5);
    store_b(8'hC3, 8'h5A);
    mw_b = 1'b0;
    check("t6_first", {4'h0, disp_b}, {4'h0, pat(8'h3C, 8'hA5)});
    @(negedge clk);
    check("t6_second", {4'h0, disp_b}, {4'h0, pat(8'hC3, 8'h5A)});
    @(negedge clk);
    check("t6_dash", {4'h0, disp_b}, {4'h0, DASH4});
    check("t6_empty", {31'd0, empty_b}, 32'd1);

    repeat (2) @(negedge clk);
    check("q_a_drained", q_a.size(), 32'd0);
    check("q_b_drained", q_b.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
